// File: rtl/nrisc_pkg.sv
// Shared definitions for the nRISC fetch front end: PC width, FSM encodings,
// next-PC source selects and the redirect penalty limit.
package nrisc_pkg;

    localparam int PC_WIDTH           = 8;
    localparam int MAX_BRANCH_PENALTY = 3;
    localparam int PEN_CNT_W          = 2;

    typedef enum logic [1:0] {
        ST_HALT    = 2'b00,
        ST_RUN     = 2'b01,
        ST_FLUSH   = 2'b10,
        ST_ILLEGAL = 2'b11
    } pc_state_e;

    typedef enum logic [2:0] {
        SEL_HOLD   = 3'd0,
        SEL_INC    = 3'd1,
        SEL_JUMP   = 3'd2,
        SEL_BRANCH = 3'd3,
        SEL_USER   = 3'd4
    } pc_sel_e;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC datapath: hold, increment, absolute jump,
// PC-relative branch and user load, selected by the controller FSM.
module pc_target_calc
    import nrisc_pkg::*;
(
    input  logic [PC_WIDTH-1:0] pc_i,
    input  pc_sel_e             sel_i,
    input  logic [PC_WIDTH-1:0] user_pc_i,
    input  logic [PC_WIDTH-1:0] jump_addr_i,
    input  logic [PC_WIDTH-1:0] br_offset_i,
    output logic [PC_WIDTH-1:0] next_pc_o
);

    always_comb begin
        next_pc_o = pc_i;
        case (sel_i)
            SEL_INC:    next_pc_o = pc_i + PC_WIDTH'(1);
            SEL_JUMP:   next_pc_o = jump_addr_i;
            // Offset and PC share a width, so the wrapping add is exactly the
            // sign-extended add truncated back to PC_WIDTH.
            SEL_BRANCH: next_pc_o = pc_i + br_offset_i;
            SEL_USER:   next_pc_o = user_pc_i;
            default:    next_pc_o = pc_i;
        endcase
    end

endmodule

// File: rtl/pc_controller.sv
// Program counter controller: HALT/RUN/FLUSH FSM, redirect penalty counter
// and PC register, all updated on the falling clock edge.
module pc_controller
    import nrisc_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0] RESET_PC       = 8'h00,
    parameter int                  BRANCH_PENALTY = 1
) (
    input  logic                CLOCK,
    input  logic                RESET,
    input  logic                START,
    input  logic                USER,
    input  logic [PC_WIDTH-1:0] USER_PC,
    input  logic                STALL,
    input  logic                JUMP,
    input  logic [PC_WIDTH-1:0] JUMP_ADDR,
    input  logic                BRANCH,
    input  logic [PC_WIDTH-1:0] BR_OFFSET,
    input  logic                HALT_INSTR,
    output logic [PC_WIDTH-1:0] PC,
    output logic                FETCH_EN,
    output logic                FLUSH,
    output logic [1:0]          STATE
);

    localparam logic [PEN_CNT_W-1:0] PEN_LAST = PEN_CNT_W'(BRANCH_PENALTY);
    localparam logic [PEN_CNT_W-1:0] PEN_ONE  = PEN_CNT_W'(1);

    // Declaration initialisers give power-up values equal to reset values.
    pc_state_e             state_q = ST_HALT;
    pc_state_e             state_d;
    logic [PC_WIDTH-1:0]   pc_q    = RESET_PC;
    logic [PC_WIDTH-1:0]   pc_d;
    logic [PEN_CNT_W-1:0]  cnt_q   = '0;
    logic [PEN_CNT_W-1:0]  cnt_d;
    pc_sel_e               sel;

    pc_target_calc u_calc (
        .pc_i        (pc_q),
        .sel_i       (sel),
        .user_pc_i   (USER_PC),
        .jump_addr_i (JUMP_ADDR),
        .br_offset_i (BR_OFFSET),
        .next_pc_o   (pc_d)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel     = SEL_HOLD;
        case (state_q)
            ST_HALT: begin
                if (USER)       sel     = SEL_USER;
                else if (START) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (USER) begin
                    sel     = SEL_USER;
                    state_d = ST_FLUSH;
                    cnt_d   = PEN_ONE;
                end else if (HALT_INSTR) begin
                    state_d = ST_HALT;
                end else if (JUMP) begin
                    sel     = SEL_JUMP;
                    state_d = ST_FLUSH;
                    cnt_d   = PEN_ONE;
                end else if (BRANCH) begin
                    sel     = SEL_BRANCH;
                    state_d = ST_FLUSH;
                    cnt_d   = PEN_ONE;
                end else if (!STALL) begin
                    sel     = SEL_INC;
                end
            end
            ST_FLUSH: begin
                // cnt_q counts FLUSH cycles already spent, starting at one.
                if (USER) begin
                    sel   = SEL_USER;
                    cnt_d = PEN_ONE;
                end else if (cnt_q == PEN_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + PEN_ONE;
                end
            end
            default: begin
                state_d = ST_HALT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(negedge CLOCK) begin
        if (RESET) begin
            state_q <= ST_HALT;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign PC       = pc_q;
    assign FETCH_EN = (state_q == ST_RUN) || (state_q == ST_FLUSH);
    assign FLUSH    = (state_q == ST_FLUSH);
    assign STATE    = state_q;

endmodule

// File: tb/tb_pc_controller.sv
// Scoreboard bench for pc_controller: two instances (penalty 1 and 3) share
// stimulus; expected PC/state are queued per edge and checked on the rising edge.
module tb_pc_controller;

    localparam logic [1:0] HLT = 2'b00;
    localparam logic [1:0] RUN = 2'b01;
    localparam logic [1:0] FLS = 2'b10;

    logic       CLOCK = 1'b0;
    logic       RESET, START, USER, STALL, JUMP, BRANCH, HALT_INSTR;
    logic [7:0] USER_PC, JUMP_ADDR, BR_OFFSET;

    logic [7:0] pc_a, pc_b;
    logic       fe_a, fe_b, fl_a, fl_b;
    logic [1:0] st_a, st_b;

    typedef struct {
        bit         w;
        logic [7:0] pc;
        logic [1:0] st;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 CLOCK = ~CLOCK;

    pc_controller #(.RESET_PC(8'h00), .BRANCH_PENALTY(1)) dut_a (
        .CLOCK(CLOCK), .RESET(RESET), .START(START), .USER(USER), .USER_PC(USER_PC),
        .STALL(STALL), .JUMP(JUMP), .JUMP_ADDR(JUMP_ADDR), .BRANCH(BRANCH),
        .BR_OFFSET(BR_OFFSET), .HALT_INSTR(HALT_INSTR),
        .PC(pc_a), .FETCH_EN(fe_a), .FLUSH(fl_a), .STATE(st_a)
    );

    pc_controller #(.RESET_PC(8'h5A), .BRANCH_PENALTY(3)) dut_b (
        .CLOCK(CLOCK), .RESET(RESET), .START(START), .USER(USER), .USER_PC(USER_PC),
        .STALL(STALL), .JUMP(JUMP), .JUMP_ADDR(JUMP_ADDR), .BRANCH(BRANCH),
        .BR_OFFSET(BR_OFFSET), .HALT_INSTR(HALT_INSTR),
        .PC(pc_b), .FETCH_EN(fe_b), .FLUSH(fl_b), .STATE(st_b)
    );

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %h want %h", tag, act, exp);
        end
    endtask

    // State updates on the falling edge, so outputs are sampled on the rising edge.
    always @(posedge CLOCK) begin
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.w == 1'b0) begin
                chk("a_pc",    pc_a,       e.pc);
                chk("a_state", {6'd0, st_a}, {6'd0, e.st});
                chk("a_fetch", {7'd0, fe_a}, {7'd0, (e.st == RUN || e.st == FLS)});
                chk("a_flush", {7'd0, fl_a}, {7'd0, (e.st == FLS)});
            end else begin
                chk("b_pc",    pc_b,       e.pc);
                chk("b_state", {6'd0, st_b}, {6'd0, e.st});
                chk("b_fetch", {7'd0, fe_b}, {7'd0, (e.st == RUN || e.st == FLS)});
                chk("b_flush", {7'd0, fl_b}, {7'd0, (e.st == FLS)});
            end
        end
    end

    task automatic ex(input bit w, input logic [7:0] pc, input logic [1:0] st);
        exp_t t;
        t.w = w; t.pc = pc; t.st = st;
        sb.push_back(t);
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic clr();
        RESET = 0; START = 0; USER = 0; STALL = 0; JUMP = 0; BRANCH = 0; HALT_INSTR = 0;
        USER_PC = 8'h00; JUMP_ADDR = 8'h00; BR_OFFSET = 8'h00;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout sb_left %0d", sb.size());
        $fatal(1, "timeout");
    end

    initial begin
        clr();
        RESET = 1;
        tick();
        // reset state on both instances
        ex(0, 8'h00, HLT); ex(1, 8'h5A, HLT); tick();
        // START, then idle cycles with a stray START while running
        clr(); START = 1;   ex(0, 8'h00, RUN); tick();
        clr();              ex(0, 8'h01, RUN); tick();
        START = 1;          ex(0, 8'h02, RUN); tick();
        clr();              ex(0, 8'h03, RUN); tick();
        // jump to 10, then backward branch by -4
        JUMP = 1; JUMP_ADDR = 8'h10; ex(0, 8'h10, FLS); tick();
        clr();                       ex(0, 8'h10, RUN); tick();
        BRANCH = 1; BR_OFFSET = 8'hFC; ex(0, 8'h0C, FLS); tick();
        clr();                       ex(0, 8'h0C, RUN); tick();
        ex(0, 8'h0D, RUN); tick();
        // stall near the top of the address space, then wrap
        JUMP = 1; JUMP_ADDR = 8'hFE; ex(0, 8'hFE, FLS); tick();
        clr();                       ex(0, 8'hFE, RUN); tick();
        STALL = 1;                   ex(0, 8'hFE, RUN); tick();
        STALL = 1;                   ex(0, 8'hFE, RUN); tick();
        clr();                       ex(0, 8'hFF, RUN); tick();
        ex(0, 8'h00, RUN); tick();
        // USER beats HALT_INSTR and JUMP; HALT_INSTR beats JUMP
        USER = 1; USER_PC = 8'h33; HALT_INSTR = 1; JUMP = 1; JUMP_ADDR = 8'h99;
        ex(0, 8'h33, FLS); tick();
        clr();                       ex(0, 8'h33, RUN); tick();
        HALT_INSTR = 1; JUMP = 1; JUMP_ADDR = 8'h99; ex(0, 8'h33, HLT); tick();
        // halt at 22, user load in HALT, restart
        clr(); JUMP = 1;             ex(0, 8'h33, HLT); tick();
        clr(); START = 1;            ex(0, 8'h33, RUN); tick();
        clr(); JUMP = 1; JUMP_ADDR = 8'h22; ex(0, 8'h22, FLS); tick();
        clr();                       ex(0, 8'h22, RUN); tick();
        HALT_INSTR = 1;              ex(0, 8'h22, HLT); tick();
        clr();                       ex(0, 8'h22, HLT); tick();
        USER = 1; USER_PC = 8'h80;   ex(0, 8'h80, HLT); tick();
        clr(); START = 1;            ex(0, 8'h80, RUN); tick();
        clr();                       ex(0, 8'h81, RUN); tick();

        // penalty-3 instance: reset to its own RESET_PC
        RESET = 1;                   ex(0, 8'h00, HLT); ex(1, 8'h5A, HLT); tick();
        clr(); START = 1;            ex(1, 8'h5A, RUN); tick();
        // JUMP and BRANCH together: jump wins, FLUSH for 3 cycles
        clr(); JUMP = 1; BRANCH = 1; JUMP_ADDR = 8'h40; BR_OFFSET = 8'h10;
        ex(1, 8'h40, FLS); tick();
        clr();                       ex(1, 8'h40, FLS); tick();
        JUMP = 1; JUMP_ADDR = 8'h77; ex(1, 8'h40, FLS); tick();
        clr();                       ex(1, 8'h40, RUN); tick();
        ex(1, 8'h41, RUN); tick();
        // USER in FLUSH reloads and restarts the penalty; others ignored
        JUMP = 1; JUMP_ADDR = 8'h50; ex(1, 8'h50, FLS); tick();
        clr(); BRANCH = 1; BR_OFFSET = 8'h08; ex(1, 8'h50, FLS); tick();
        clr(); USER = 1; USER_PC = 8'h60; ex(1, 8'h60, FLS); tick();
        clr(); HALT_INSTR = 1; STALL = 1; ex(1, 8'h60, FLS); tick();
        clr(); START = 1;            ex(1, 8'h60, FLS); tick();
        clr();                       ex(1, 8'h60, RUN); tick();
        // reset mid-FLUSH with simultaneous USER
        JUMP = 1; JUMP_ADDR = 8'h90; ex(1, 8'h90, FLS); tick();
        clr(); RESET = 1; USER = 1; USER_PC = 8'hAA;
        ex(0, 8'h00, HLT); ex(1, 8'h5A, HLT); tick();
        clr();                       ex(1, 8'h5A, HLT); tick();

        chk("sb_drain", 8'(sb.size()), 8'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
